// File: rtl/tt_bcd_updown_display.sv
// tt_bcd_updown_display
// Debounced N-digit BCD up/down counter driving a time-multiplexed 7-segment
// display. The display blanks leading zeros and shows a sticky limit indicator
// on the dp of digit 0. Buttons are synchronised and debounced, and only
// press edges count.
module tt_bcd_updown_display #(
  parameter int NUM_DIGITS      = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REFRESH_CYCLES  = 64,
  parameter int WRAP            = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic                    btn_clr,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    limit_pulse
);

  localparam int CW      = 4 * NUM_DIGITS;
  localparam int DBW     = $clog2(DEBOUNCE_CYCLES);
  localparam int RFW     = $clog2(REFRESH_CYCLES);
  localparam int DIW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CLR = 2;

  // Button input path
  logic [2:0]          btn_raw;
  logic [2:0]          sync1, sync2;   // two-flop synchroniser stages
  logic [2:0]          accepted;       // debounced level per button
  logic [2:0]          armed;          // button has been seen released since reset
  logic [2:0]          press;          // one-cycle accepted 0->1 events
  logic [2:0][DBW-1:0] db_cnt;
  logic [1:0]          primed;         // synchroniser holds real samples

  // Counter state
  logic [CW-1:0] count, count_next, inc_val, dec_val;
  logic          carry, borrow, at_max, at_zero;
  logic          sticky, sticky_next, limit_next;
  logic          ev_clr, ev_inc, ev_dec;

  // Display scan state
  logic [RFW-1:0]        scan_cnt, scan_next;
  logic [DIW-1:0]        digit_idx, idx_next;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic [7:0]            seg_next;

  assign btn_raw   = {btn_clr, btn_dec, btn_inc};
  assign count_bcd = count;

  // Synchronise, debounce and edge-detect each button. A level held across
  // reset is never armed, so it cannot produce a press after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      accepted <= '0;
      armed    <= '0;
      press    <= '0;
      db_cnt   <= '0;
      primed   <= '0;
    end else begin
      // NOTE: every flop is updated with <= so all flops see the values from
      // before the edge, whatever order the statements appear in.
      sync1  <= btn_raw;
      sync2  <= sync1;
      primed <= {primed[0], 1'b1};
      press  <= '0;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == accepted[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[b]   <= '0;
          accepted[b] <= sync2[b];
          press[b]    <= sync2[b] & armed[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
        if (primed[1] && !sync2[b]) armed[b] <= 1'b1;
      end
    end
  end

  assign ev_clr = ena & press[BTN_CLR];
  assign ev_inc = ena & press[BTN_INC] & ~press[BTN_DEC];
  assign ev_dec = ena & press[BTN_DEC] & ~press[BTN_INC];

  // BCD ripple increment and decrement of the current count
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred. The carry and
    // borrow chains use blocking updates on purpose: each digit sees the
    // value left by the digit below it.
    inc_val = count;
    dec_val = count;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (count[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count[4*k +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
    at_max  = carry;
    at_zero = borrow;
  end

  // Next count, sticky flag and limit pulse. Priority is clr, then
  // inc+dec cancel, then inc, then dec.
  always_comb begin
    count_next  = count;
    sticky_next = sticky;
    limit_next  = 1'b0;
    if (ev_clr) begin
      count_next  = '0;
      sticky_next = 1'b0;
    end else if (ev_inc) begin
      if (at_max) begin
        limit_next  = 1'b1;
        sticky_next = 1'b1;
        if (WRAP != 0) count_next = inc_val;
      end else begin
        count_next = inc_val;
      end
    end else if (ev_dec) begin
      if (at_zero) begin
        limit_next  = 1'b1;
        sticky_next = 1'b1;
        if (WRAP != 0) count_next = dec_val;
      end else begin
        count_next = dec_val;
      end
    end
  end

  // Count, sticky flag and limit pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      sticky      <= 1'b0;
      limit_pulse <= 1'b0;
    end else begin
      count       <= count_next;
      sticky      <= sticky_next;
      limit_pulse <= limit_next;
    end
  end

  // Scan timing: hold each digit for REFRESH_CYCLES clocks, then move on
  always_comb begin
    scan_next = scan_cnt + 1'b1;
    idx_next  = digit_idx;
    if (scan_cnt == RFW'(REFRESH_CYCLES - 1)) begin
      scan_next = '0;
      idx_next  = (digit_idx == DIW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end
  end

  // Segment pattern for the digit selected next cycle. It is built from the
  // next count, so segments and digit select change in the same register
  // update, and count changes show up immediately, even mid-dwell.
  always_comb begin
    nib      = 4'd0;
    upper_nz = 1'b0;
    sel_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (DIW'(k) == idx_next) begin
        nib         = count_next[4*k +: 4];
        sel_next[k] = 1'b1;
      end
      if (DIW'(k) >= idx_next && count_next[4*k +: 4] != 4'd0) upper_nz = 1'b1;
    end
    case (nib)
      4'd0:    seg_next = 8'h3F;
      4'd1:    seg_next = 8'h06;
      4'd2:    seg_next = 8'h5B;
      4'd3:    seg_next = 8'h4F;
      4'd4:    seg_next = 8'h66;
      4'd5:    seg_next = 8'h6D;
      4'd6:    seg_next = 8'h7D;
      4'd7:    seg_next = 8'h07;
      4'd8:    seg_next = 8'h7F;
      4'd9:    seg_next = 8'h6F;
      default: seg_next = 8'h00;
    endcase
    if (idx_next != '0 && !upper_nz) seg_next = 8'h00;
    if (idx_next == '0 && sticky_next) seg_next[7] = 1'b1;
  end

  // Scan counter, digit index and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      digit_sel <= NUM_DIGITS'(1);
      seg_out   <= 8'h3F;
    end else begin
      scan_cnt  <= scan_next;
      digit_idx <= idx_next;
      digit_sel <= sel_next;
      seg_out   <= seg_next;
    end
  end

endmodule

// File: tb/tb_tt_bcd_updown_display.sv
// tb_tt_bcd_updown_display
// Two instances share the button stimulus. One wraps at the limits and one
// saturates. A decimal reference model predicts each accepted press and
// queues the expected state for the cycle it must appear. A negedge monitor
// checks the count, the limit pulse, the scan position and the segments
// every cycle.
module tb_tt_bcd_updown_display;

  localparam int ND   = 2;
  localparam int DB   = 4;
  localparam int RF   = 4;
  localparam int LAT  = 3 + DB;  // stable raw edge -> visible count change
  localparam int MAXV = 99;
  localparam logic [7:0] SEG_TAB [10] =
    '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_clr = 1'b0;
  logic [7:0] seg  [2];
  logic [1:0] dsel [2];
  logic [7:0] cnt  [2];
  logic       lim  [2];

  tt_bcd_updown_display #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB),
                          .REFRESH_CYCLES(RF), .WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_clr(btn_clr), .seg_out(seg[0]), .digit_sel(dsel[0]),
    .count_bcd(cnt[0]), .limit_pulse(lim[0]));

  tt_bcd_updown_display #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB),
                          .REFRESH_CYCLES(RF), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_clr(btn_clr), .seg_out(seg[1]), .digit_sel(dsel[1]),
    .count_bcd(cnt[1]), .limit_pulse(lim[1]));

  always #5 clk = ~clk;

  // Clock edges since the last reset release
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int cyc;
    int val    [2];
    bit lim    [2];
    bit sticky [2];
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_val    [2] = '{0, 0};   // model state, advanced at stimulus time
  bit   m_sticky [2] = '{0, 0};
  int   cur_val  [2] = '{0, 0};   // expected DUT state, advanced at pop time
  bit   cur_sticky [2] = '{0, 0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Two-digit display: tens blank when zero, dp on units while sticky
  function automatic logic [7:0] seg_model(int v, bit stk, int d);
    if (d != 0) return (v / 10 == 0) ? 8'h00 : SEG_TAB[v / 10];
    return SEG_TAB[v % 10] | (stk ? 8'h80 : 8'h00);
  endfunction

  // Monitor: apply due expectations, then check every output of both DUTs
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   hit;
    int   d;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cur_val[i]    = 0;
        cur_sticky[i] = 1'b0;
      end
    end else begin
      hit = 1'b0;
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("event_overdue", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e   = sb.pop_front();
        hit = 1'b1;
      end
      d = (cyc / RF) % ND;
      for (int i = 0; i < 2; i++) begin
        if (hit) begin
          cur_val[i]    = e.val[i];
          cur_sticky[i] = e.sticky[i];
        end
        check($sformatf("count_bcd[%0d]", i), 32'(cnt[i]), 32'(to_bcd(cur_val[i])));
        check($sformatf("limit_pulse[%0d]", i), 32'(lim[i]), (hit && e.lim[i]) ? 32'd1 : 32'd0);
        check($sformatf("digit_sel[%0d]", i), 32'(dsel[i]), 32'(1 << d));
        check($sformatf("seg_out[%0d]", i), 32'(seg[i]),
              32'(seg_model(cur_val[i], cur_sticky[i], d)));
      end
    end
  end

  task automatic drive(logic [2:0] m);  // m = {clr, dec, inc}
    btn_inc = m[0];
    btn_dec = m[1];
    btn_clr = m[2];
  endtask

  // Advance the model for a press accepted now and queue its outcome
  task automatic fire(logic [2:0] m);
    exp_t e;
    e.cyc = cyc + LAT;
    for (int i = 0; i < 2; i++) begin
      e.lim[i] = 1'b0;
      if (m[2]) begin
        m_val[i]    = 0;
        m_sticky[i] = 1'b0;
      end else if (m[0] && m[1]) begin
        m_val[i] = m_val[i];
      end else if (m[0]) begin
        if (m_val[i] == MAXV) begin
          e.lim[i] = 1'b1;
          m_sticky[i] = 1'b1;
          if (i == 0) m_val[i] = 0;
        end else m_val[i] = m_val[i] + 1;
      end else if (m[1]) begin
        if (m_val[i] == 0) begin
          e.lim[i] = 1'b1;
          m_sticky[i] = 1'b1;
          if (i == 0) m_val[i] = MAXV;
        end else m_val[i] = m_val[i] - 1;
      end
      e.val[i]    = m_val[i];
      e.sticky[i] = m_sticky[i];
    end
    sb.push_back(e);
  endtask

  // Bouncy press: short glitches, a stable level, then a clean release
  task automatic press(logic [2:0] m, bit en);
    int nb = $urandom_range(0, 2);
    repeat (nb) begin
      drive(m);
      repeat ($urandom_range(1, 2)) @(negedge clk);
      drive(3'b000);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drive(m);
    ena = en;
    if (en) fire(m);
    repeat (DB + 5) @(negedge clk);
    ena = 1'b1;
    drive(3'b000);
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic clear_model();
    sb.delete();
    m_val    = '{0, 0};
    m_sticky = '{0, 0};
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int g;
    int r;
    logic [2:0] m;
    #1 rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single clean increment
    press(3'b001, 1'b1);

    // Short glitches never reach the debounce threshold
    repeat (10) begin
      btn_inc = 1'b1;
      @(negedge clk);
      btn_inc = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    // Count up to 99, then one more: wrap versus saturate
    repeat (98) press(3'b001, 1'b1);
    press(3'b001, 1'b1);

    // Borrow across digits from 10, then decrement at zero
    press(3'b100, 1'b1);
    repeat (10) press(3'b001, 1'b1);
    press(3'b010, 1'b1);
    press(3'b100, 1'b1);
    press(3'b010, 1'b1);

    // Simultaneous presses and disabled presses
    press(3'b011, 1'b1);
    press(3'b001, 1'b1);
    press(3'b101, 1'b1);
    press(3'b010, 1'b1);
    press(3'b110, 1'b1);
    press(3'b001, 1'b0);
    press(3'b010, 1'b0);

    // Random mix
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 4)       m = 3'b001;
      else if (r < 7)  m = 3'b010;
      else if (r == 7) m = 3'b100;
      else if (r == 8) m = 3'b011;
      else             m = 3'b110;
      press(m, $urandom_range(0, 7) != 0);
    end

    // Reset mid-debounce while digit 1 is on, with the button held across it
    press(3'b001, 1'b1);
    g = 0;
    while ((cyc % 8) != 2 && g < 16) begin
      @(negedge clk);
      g++;
    end
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_count_bcd[%0d]", i), 32'(cnt[i]), 32'h0);
      check($sformatf("rst_digit_sel[%0d]", i), 32'(dsel[i]), 32'h1);
      check($sformatf("rst_seg_out[%0d]", i), 32'(seg[i]), 32'h3F);
      check($sformatf("rst_limit_pulse[%0d]", i), 32'(lim[i]), 32'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    press(3'b001, 1'b1);
    press(3'b010, 1'b1);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
